u8outbuf: RTL and testbench

U8OUTBUF -- requirements
Module: u8outbuf

---
 rtl/u8outbuf_if.sv | 30 +++
 rtl/u8outbuf.sv | 158 +++++++++++++++
 tb/tb_u8outbuf.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/u8outbuf_if.sv
// Frame-in / bus-write-out signal bundle for u8outbuf.
// Latency: none (wires only).
// Backpressure: out_rdy throttles frame producers, wr_rdy throttles the write bus.
interface u8outbuf_if #(
   parameter int Np = 32,
   parameter int AW = 29
);
   // frame side (MAC array -> buffer)
   logic                   acvalid;
   logic [Np-1:0][7:0]     accd;
   logic [Np-1:0][AW-1:0]  out_adr;
   logic [Np-1:0]          oen;
   logic                   out_rdy;
   // write side (buffer -> bus)
   logic                   wr_valid;
   logic [AW-1:0]          wr_adr;
   logic [31:0]            wr_data;
   logic [3:0]             wr_strb;
   logic                   wr_rdy;

   modport master (
      output acvalid, accd, out_adr, oen, wr_rdy,
      input  out_rdy, wr_valid, wr_adr, wr_data, wr_strb
   );

   modport slave (
      input  acvalid, accd, out_adr, oen, wr_rdy,
      output out_rdy, wr_valid, wr_adr, wr_data, wr_strb
   );
endinterface

// File: rtl/u8outbuf.sv
// Buffers u8 MAC output frames and packs enabled channels into 32-bit byte-strobed bus writes.
// Latency: frame strobe at cycle t into an empty idle block gives wr_valid at t+2.
// Backpressure: out_rdy low when the FIFO is full (frames then dropped, overflow sticky); wr_* held until wr_rdy.
module u8outbuf #(
   parameter int Np    = 32,
   parameter int DEPTH = 4,
   parameter int AW    = 29
) (
   input  logic        clk,
   input  logic        xrst,
   input  logic        clr,
   u8outbuf_if.slave   bus,
   output logic        busy,
   output logic        overflow,
   output logic [31:0] wcount
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = $clog2(Np + 1);

   typedef struct packed {
      logic [Np-1:0][7:0]    accd;
      logic [Np-1:0][AW-1:0] adr;
      logic [Np-1:0]         oen;
   } frame_t;

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   frame_t        mem_q [DEPTH];
   frame_t        work_q;
   frame_t        frame_in;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          overflow_q, overflow_d;
   logic [31:0]   wcount_q, wcount_d;
   logic          full, push, pop, valid, hs;

   // word builder results
   logic          found;
   logic          more;
   logic [AW-3:0] word_a;
   logic [3:0]    strb;
   logic [31:0]   data;
   logic [IW-1:0] end_idx;
   logic [1:0]    lane;

   assign frame_in = {bus.accd, bus.out_adr, bus.oen};

   // FIFO bookkeeping: a full FIFO still takes a frame when the head leaves in the same cycle
   always_comb begin
      full       = (cnt_q == CW'(DEPTH));
      push       = bus.acvalid && (!full || pop);
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overflow_d = overflow_q | (bus.acvalid & ~push);
      hs         = valid & bus.wr_rdy;
      wcount_d   = wcount_q + 32'(hs);
   end

   // Word builder: first enabled channel at/after idx opens a word; later enabled channels
   // join while they share the word address and hit a free lane; disabled ones are skipped.
   // end_idx is the first enabled channel left over (or Np when the frame is exhausted).
   always_comb begin
      found   = 1'b0;
      more    = 1'b0;
      word_a  = '0;
      strb    = '0;
      data    = '0;
      end_idx = IW'(Np);
      lane    = '0;
      for (int j = 0; j < Np; j++) begin
         lane = work_q.adr[j][1:0];
         if (j >= int'(idx_q) && work_q.oen[j] && !more) begin
            if (!found) begin
               found                  = 1'b1;
               word_a                 = work_q.adr[j][AW-1:2];
               strb[lane]             = 1'b1;
               data[{lane, 3'b000}+:8] = work_q.accd[j];
            end else if (work_q.adr[j][AW-1:2] == word_a && !strb[lane]) begin
               strb[lane]             = 1'b1;
               data[{lane, 3'b000}+:8] = work_q.accd[j];
            end else begin
               more    = 1'b1;
               end_idx = IW'(j);
            end
         end
      end
   end

   // FSM next state: IDLE loads the head frame, SCAN emits words until the frame is used up
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pop     = 1'b0;
      valid   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cnt_q != '0) begin
               pop     = 1'b1;
               idx_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (!found) begin
               state_d = IDLE;
            end else begin
               valid = 1'b1;
               if (bus.wr_rdy) begin
                  idx_d = end_idx;
                  if (!more) state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers; reset and soft clear have the same effect, so one branch serves both
   always_ff @(posedge clk) begin
      if (!xrst || clr) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         state_q    <= IDLE;
         idx_q      <= '0;
         overflow_q <= 1'b0;
         wcount_q   <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
         overflow_q <= overflow_d;
         wcount_q   <= wcount_d;
      end
   end

   // Frame storage and working copy; contents are don't-care while the control side is empty/IDLE
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= frame_in;
      if (pop)  work_q          <= mem_q[rd_ptr_q];
   end

   assign bus.out_rdy  = !full;
   assign bus.wr_valid = valid;
   assign bus.wr_adr   = valid ? {word_a, 2'b00} : '0;
   assign bus.wr_data  = valid ? data : '0;
   assign bus.wr_strb  = valid ? strb : '0;
   assign busy         = (cnt_q != '0) || (state_q != IDLE);
   assign overflow     = overflow_q;
   assign wcount       = wcount_q;
endmodule

// File: tb/tb_u8outbuf.sv
// Self-checking bench for u8outbuf (Np=4, DEPTH=2): frame vector table plus corner sequences.
// Expected writes are queued when a frame is driven and popped when the DUT completes a write.
// Bounded waits everywhere; failures print FAIL lines and the summary counts them.
module tb_u8outbuf;
   localparam int NP    = 4;
   localparam int DEPTH = 2;
   localparam int AW    = 29;

   typedef struct packed {
      logic [AW-1:0] adr;
      logic [31:0]   data;
      logic [3:0]    strb;
   } exp_t;

   typedef struct packed {
      logic [NP-1:0][AW-1:0] adr;
      logic [NP-1:0][7:0]    d;
      logic [NP-1:0]         oen;
      logic [2:0]            nw;
      logic [3:0][AW-1:0]    eadr;
      logic [3:0][31:0]      edat;
      logic [3:0][3:0]       estrb;
   } vec_t;

   logic        clk = 1'b0;
   logic        xrst;
   logic        clr;
   logic        busy;
   logic        overflow;
   logic [31:0] wcount;

   u8outbuf_if #(.Np(NP), .AW(AW)) bus ();

   u8outbuf #(.Np(NP), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk      (clk),
      .xrst     (xrst),
      .clr      (clr),
      .bus      (bus),
      .busy     (busy),
      .overflow (overflow),
      .wcount   (wcount)
   );

   always #5 clk = ~clk;

   int   n_checks   = 0;
   int   n_fail     = 0;
   int   cyc        = 0;
   int   exp_wcount = 0;
   exp_t exp_q[$];
   int   hs_cyc[$];
   vec_t vecs [6];
   exp_t mon_e;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_adr   = '0;
   logic [31:0]   prev_data  = '0;
   logic [3:0]    prev_strb  = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                               input logic [31:0] dw, input logic [NP-1:0] oen, input int nw);
      vec_t v = '0;
      v.adr[0] = a0;
      v.adr[1] = a1;
      v.adr[2] = a2;
      v.adr[3] = a3;
      v.d      = dw;
      v.oen    = oen;
      v.nw     = 3'(nw);
      return v;
   endfunction

   function automatic vec_t addw(input vec_t vin, input int k, input logic [AW-1:0] a,
                                 input logic [31:0] dat, input logic [3:0] s);
      vec_t v = vin;
      v.eadr[k]  = a;
      v.edat[k]  = dat;
      v.estrb[k] = s;
      return v;
   endfunction

   // drive one frame for one cycle; queue its writes when it is expected to be taken
   task automatic send(input vec_t v, input bit accept);
      bus.acvalid = 1'b1;
      bus.accd    = v.d;
      bus.out_adr = v.adr;
      bus.oen     = v.oen;
      if (accept) begin
         for (int k = 0; k < int'(v.nw); k++) begin
            exp_q.push_back({v.eadr[k], v.edat[k], v.estrb[k]});
            exp_wcount++;
         end
      end
      @(posedge clk); #1;
      bus.acvalid = 1'b0;
      for (int k = 0; k < NP; k++) begin
         bus.accd[k]    = 8'($urandom);
         bus.out_adr[k] = AW'($urandom);
      end
      bus.oen = NP'($urandom);
   endtask

   task automatic drain(input string tag, input bit toggle);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 600) begin
         @(posedge clk); #1;
         if (toggle) bus.wr_rdy = ~bus.wr_rdy;
         n++;
      end
      @(posedge clk); #1;
      chk({tag, "_drained"}, 64'((busy || exp_q.size() != 0) ? 1 : 0), 64'd0);
      chk({tag, "_wcount"}, 64'(wcount), 64'(exp_wcount));
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!bus.wr_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_valid_seen"}, 64'(bus.wr_valid), 64'd1);
   endtask

   always @(posedge clk) cyc = cyc + 1;

   // scoreboard and hold-stability monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.wr_valid && bus.wr_rdy) begin
         hs_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got adr %0h data %0h strb %0h, required no write",
                     bus.wr_adr, bus.wr_data, bus.wr_strb);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_adr", 64'(bus.wr_adr), 64'(mon_e.adr));
            chk("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
            chk("wr_strb", 64'(bus.wr_strb), 64'(mon_e.strb));
         end
      end
      if (prev_stall) begin
         chk("hold_valid", 64'(bus.wr_valid), 64'd1);
         chk("hold_adr", 64'(bus.wr_adr), 64'(prev_adr));
         chk("hold_data", 64'(bus.wr_data), 64'(prev_data));
         chk("hold_strb", 64'(bus.wr_strb), 64'(prev_strb));
      end
      prev_stall = bus.wr_valid && !bus.wr_rdy && xrst && !clr;
      prev_adr   = bus.wr_adr;
      prev_data  = bus.wr_data;
      prev_strb  = bus.wr_strb;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got simulation still running, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      xrst        = 1'b0;
      clr         = 1'b0;
      bus.acvalid = 1'b0;
      bus.accd    = '0;
      bus.out_adr = '0;
      bus.oen     = '0;
      bus.wr_rdy  = 1'b0;

      // single full word
      vecs[0] = mk(29'h100, 29'h101, 29'h102, 29'h103, 32'h44332211, 4'b1111, 1);
      vecs[0] = addw(vecs[0], 0, 29'h100, 32'h44332211, 4'hF);
      // word-address change splits into three writes
      vecs[1] = mk(29'h102, 29'h103, 29'h104, 29'h108, 32'h44332211, 4'b1111, 3);
      vecs[1] = addw(vecs[1], 0, 29'h100, 32'h22110000, 4'hC);
      vecs[1] = addw(vecs[1], 1, 29'h104, 32'h00000033, 4'h1);
      vecs[1] = addw(vecs[1], 2, 29'h108, 32'h00000044, 4'h1);
      // lane collision on the same word
      vecs[2] = mk(29'h100, 29'h100, 29'h200, 29'h300, 32'h44332211, 4'b0011, 2);
      vecs[2] = addw(vecs[2], 0, 29'h100, 32'h00000011, 4'h1);
      vecs[2] = addw(vecs[2], 1, 29'h100, 32'h00000022, 4'h1);
      // nothing enabled
      vecs[3] = mk(29'h040, 29'h041, 29'h042, 29'h043, 32'hDEADBEEF, 4'b0000, 0);
      // disabled channel in the middle does not end the word
      vecs[4] = mk(29'h203, 29'h999, 29'h201, 29'h200, 32'hD4C3B2A1, 4'b1101, 1);
      vecs[4] = addw(vecs[4], 0, 29'h200, 32'hA100C3D4, 4'hB);
      // descending words, assorted lanes, top of address range
      vecs[5] = mk(29'h10E, 29'h109, 29'h107, 29'h1FFFFFF0, 32'h04030201, 4'b1111, 4);
      vecs[5] = addw(vecs[5], 0, 29'h10C, 32'h00010000, 4'h4);
      vecs[5] = addw(vecs[5], 1, 29'h108, 32'h00000200, 4'h2);
      vecs[5] = addw(vecs[5], 2, 29'h104, 32'h03000000, 4'h8);
      vecs[5] = addw(vecs[5], 3, 29'h1FFFFFF0, 32'h00000004, 4'h1);

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
      chk("rst_wr_adr", 64'(bus.wr_adr), 64'd0);
      chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
      chk("rst_wr_strb", 64'(bus.wr_strb), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_wcount", 64'(wcount), 64'd0);
      chk("rst_out_rdy", 64'(bus.out_rdy), 64'd1);

      @(posedge clk); #1;
      xrst       = 1'b1;
      bus.wr_rdy = 1'b1;

      // table: each frame into an idle block, latency and write contents
      for (int i = 0; i < 6; i++) begin
         send(vecs[i], 1'b1);
         @(negedge clk);
         chk($sformatf("vec%0d_valid_t1", i), 64'(bus.wr_valid), 64'd0);
         @(negedge clk);
         chk($sformatf("vec%0d_valid_t2", i), 64'(bus.wr_valid), 64'(vecs[i].nw != 0));
         if (vecs[i].nw == 0) begin
            chk($sformatf("vec%0d_scan_busy", i), 64'(busy), 64'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_scan_done", i), 64'(busy), 64'd0);
         end
         drain($sformatf("vec%0d", i), 1'b0);
      end

      // back-to-back frames: no bubbles inside a frame, one IDLE cycle between frames
      hs_cyc.delete();
      send(vecs[1], 1'b1);
      send(vecs[0], 1'b1);
      drain("b2b", 1'b0);
      chk("b2b_hs_count", 64'(hs_cyc.size()), 64'd4);
      if (hs_cyc.size() == 4) begin
         chk("b2b_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
         chk("b2b_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd1);
         chk("b2b_gap23", 64'(hs_cyc[3] - hs_cyc[2]), 64'd2);
      end

      // overflow: with the bus stalled the first frame sits in the working registers,
      // so the two-entry FIFO fills on the next two frames and the fourth is dropped
      bus.wr_rdy = 1'b0;
      send(vecs[2], 1'b1);
      send(vecs[5], 1'b1);
      @(negedge clk);
      chk("ovf_rdy_one_queued", 64'(bus.out_rdy), 64'd1);
      send(vecs[0], 1'b1);
      @(negedge clk);
      chk("ovf_rdy_full", 64'(bus.out_rdy), 64'd0);
      chk("ovf_flag_before", 64'(overflow), 64'd0);
      send(vecs[1], 1'b0);
      @(negedge clk);
      chk("ovf_flag_set", 64'(overflow), 64'd1);
      chk("ovf_busy", 64'(busy), 64'd1);
      chk("ovf_stalled_adr", 64'(bus.wr_adr), 64'h100);
      // drain with wr_rdy toggling every cycle
      @(posedge clk); #1;
      drain("toggle", 1'b1);
      chk("ovf_sticky", 64'(overflow), 64'd1);

      // soft clear from the idle-with-overflow state
      bus.wr_rdy = 1'b1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      exp_wcount = 0;
      @(negedge clk);
      chk("clr_overflow", 64'(overflow), 64'd0);
      chk("clr_wcount", 64'(wcount), 64'd0);
      chk("clr_busy", 64'(busy), 64'd0);
      chk("clr_out_rdy", 64'(bus.out_rdy), 64'd1);

      // soft clear abandons a pending write
      @(posedge clk); #1;
      bus.wr_rdy = 1'b0;
      send(vecs[1], 1'b1);
      wait_valid("clrmid");
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      exp_q.delete();
      exp_wcount = 0;
      @(negedge clk);
      chk("clrmid_valid", 64'(bus.wr_valid), 64'd0);
      chk("clrmid_busy", 64'(busy), 64'd0);
      chk("clrmid_wcount", 64'(wcount), 64'd0);
      @(posedge clk); #1;
      bus.wr_rdy = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("clrmid_no_writes", 64'(wcount), 64'd0);

      // reset during SCAN with a pending write and a queued frame
      bus.wr_rdy = 1'b0;
      send(vecs[1], 1'b1);
      send(vecs[0], 1'b1);
      wait_valid("rstmid");
      xrst = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      exp_wcount = 0;
      @(negedge clk);
      chk("rstmid_valid", 64'(bus.wr_valid), 64'd0);
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_wcount", 64'(wcount), 64'd0);
      chk("rstmid_out_rdy", 64'(bus.out_rdy), 64'd1);
      @(posedge clk); #1;
      xrst       = 1'b1;
      bus.wr_rdy = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("rstmid_no_writes", 64'(wcount), 64'd0);
      chk("rstmid_idle", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
